// File: rtl/uart_top.sv
// Full-duplex 8N1 UART: one-byte transmitter and receiver sharing a single baud divider.
// TX shifts data_in out LSB first; RX oversamples a synchronized rx at mid-bit.
module uart_top #(
   parameter int BAUD_DIV = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   input  logic [7:0] data_in,
   input  logic       tx_start,
   output logic       tx,
   output logic       rx_done,
   output logic       tx_busy,
   output logic [7:0] data_out
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] C_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] C_HALF = CW'(BAUD_DIV / 2);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // ---------------- transmitter ----------------
   state_t          r_tx_state, w_tx_next;
   logic [CW-1:0]   r_tx_cnt;
   logic [2:0]      r_tx_idx;
   logic [7:0]      r_tx_sh;
   logic            w_tx_tick;

   assign w_tx_tick = (r_tx_cnt == C_LAST);

   always_ff @(posedge clk) begin
      if (reset_n) r_tx_state <= S_IDLE;
      else         r_tx_state <= w_tx_next;
   end

   always_comb begin
      w_tx_next = r_tx_state;
      case (r_tx_state)
         S_IDLE:  if (tx_start)                        w_tx_next = S_START;
         S_START: if (w_tx_tick)                       w_tx_next = S_DATA;
         S_DATA:  if (w_tx_tick && r_tx_idx == 3'd7)   w_tx_next = S_STOP;
         S_STOP:  if (w_tx_tick)                       w_tx_next = S_IDLE;
         default:                                      w_tx_next = S_IDLE;
      endcase
   end

   always_comb begin
      tx      = 1'b1;
      tx_busy = (r_tx_state != S_IDLE);
      case (r_tx_state)
         S_START: tx = 1'b0;
         S_DATA:  tx = r_tx_sh[0];
         default: tx = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         r_tx_cnt <= '0;
         r_tx_idx <= '0;
         r_tx_sh  <= '0;
      end else if (r_tx_state == S_IDLE) begin
         r_tx_cnt <= '0;
         r_tx_idx <= '0;
         if (tx_start) r_tx_sh <= data_in;
      end else begin
         r_tx_cnt <= w_tx_tick ? '0 : r_tx_cnt + CW'(1);
         if (r_tx_state == S_DATA && w_tx_tick) begin
            r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
            r_tx_idx <= r_tx_idx + 3'd1;
         end
      end
   end

   // ---------------- receiver ----------------
   state_t          r_rx_state, w_rx_next;
   logic            r_rx_s1, r_rx_s2, r_rx_q;
   logic [CW-1:0]   r_rx_cnt;
   logic [2:0]      r_rx_idx;
   logic [7:0]      r_rx_sh;
   logic            w_rx, w_rx_fall, w_rx_last, w_rx_half, w_rx_load;

   assign w_rx      = r_rx_s2;
   assign w_rx_fall = r_rx_q & ~r_rx_s2;
   assign w_rx_last = (r_rx_cnt == C_LAST);
   assign w_rx_half = (r_rx_cnt == C_HALF);

   always_ff @(posedge clk) begin
      if (reset_n) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
         r_rx_q  <= 1'b1;
      end else begin
         r_rx_s1 <= rx;
         r_rx_s2 <= r_rx_s1;
         r_rx_q  <= r_rx_s2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n) r_rx_state <= S_IDLE;
      else         r_rx_state <= w_rx_next;
   end

   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         S_IDLE:  if (w_rx_fall)                      w_rx_next = S_START;
         S_START: if (w_rx_half)                      w_rx_next = w_rx ? S_IDLE : S_DATA;
         S_DATA:  if (w_rx_last && r_rx_idx == 3'd7)  w_rx_next = S_STOP;
         S_STOP:  if (w_rx_last)                      w_rx_next = S_IDLE;
         default:                                     w_rx_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_rx_load = (r_rx_state == S_STOP) && w_rx_last && w_rx;
   end

   // The edge-detect cycle is tick 0 of the start bit, so START begins at 1.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         r_rx_cnt <= '0;
         r_rx_idx <= '0;
         r_rx_sh  <= '0;
         rx_done  <= 1'b0;
         data_out <= 8'h00;
      end else begin
         rx_done <= w_rx_load;
         if (w_rx_load) data_out <= r_rx_sh;
         case (r_rx_state)
            S_IDLE: begin
               r_rx_cnt <= w_rx_fall ? CW'(1) : '0;
               r_rx_idx <= '0;
            end
            S_START: r_rx_cnt <= w_rx_half ? '0 : r_rx_cnt + CW'(1);
            S_DATA: begin
               r_rx_cnt <= w_rx_last ? '0 : r_rx_cnt + CW'(1);
               if (w_rx_last) begin
                  r_rx_sh  <= {w_rx, r_rx_sh[7:1]};
                  r_rx_idx <= r_rx_idx + 3'd1;
               end
            end
            default: r_rx_cnt <= w_rx_last ? '0 : r_rx_cnt + CW'(1);
         endcase
      end
   end

endmodule

// File: tb/tb_uart_top.sv
// Bench for uart_top: frame-level TX model checked every cycle, RX byte scoreboard,
// literal frames for the directed cases, then randomized TX, RX and loopback traffic.
module tb_uart_top;

   localparam int BD = 4;
   localparam int FR = 10 * BD;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       rx_drv = 1'b1;
   logic       lb = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       rx_w;
   logic       tx, rx_done, tx_busy;
   logic [7:0] data_out;

   assign rx_w = lb ? tx : rx_drv;

   always #5 clk = ~clk;

   uart_top #(.BAUD_DIV(BD)) dut (
      .clk(clk), .reset_n(reset_n), .rx(rx_w), .data_in(data_in), .tx_start(tx_start),
      .tx(tx), .rx_done(rx_done), .tx_busy(tx_busy), .data_out(data_out)
   );

   int n_checks = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // TX model: a frame is a 10-bit vector; each bit holds for BD cycles.
   int          m_left = 0;
   logic [9:0]  m_frame = 10'h3FF;
   logic        m_rst_q = 1'b0;
   logic [13:0] cyc = '0;

   always @(posedge clk) begin
      cyc     <= cyc + 14'd1;
      m_rst_q <= reset_n;
      if (reset_n) m_left <= 0;
      else if (m_left == 0) begin
         if (tx_start === 1'b1) begin
            m_frame <= {1'b1, data_in, 1'b0};
            m_left  <= FR;
         end
      end else m_left <= m_left - 1;
   end

   // RX scoreboard: bytes the bench expects, in order.
   logic [7:0] exp_q[$];
   logic [7:0] m_dout = 8'h00;
   logic [7:0] exp_b;
   logic       etx, ebusy;
   logic [3:0] bi;
   logic       txlog [0:16383];
   logic       busylog [0:16383];

   always @(negedge clk) begin
      ebusy = (m_left != 0);
      bi    = 4'((FR - m_left) / BD);
      etx   = ebusy ? m_frame[bi] : 1'b1;
      txlog[cyc]   <= tx;
      busylog[cyc] <= tx_busy;
      chk("tx", 32'(tx), 32'(etx));
      chk("tx_busy", 32'(tx_busy), 32'(ebusy));
      if (m_rst_q) begin
         chk("rst_rx_done", 32'(rx_done), 32'd0);
         chk("rst_data_out", 32'(data_out), 32'd0);
         m_dout <= 8'h00;
         exp_q.delete();
      end else if (rx_done === 1'b1) begin
         if (exp_q.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
         else begin
            exp_b = exp_q.pop_front();
            chk("rx_data", 32'(data_out), 32'(exp_b));
            m_dout <= exp_b;
         end
      end else chk("data_out_hold", 32'(data_out), 32'(m_dout));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Send one byte with tx_start held 'hold' cycles, then compare mid-bit samples to a literal.
   task automatic tx_lit(input logic [7:0] b, input logic [9:0] bits, input int hold);
      logic [13:0] c1, ix;
      int busy_n;
      data_in  = b;
      tx_start = 1'b1;
      tick(1);
      c1 = cyc;
      if (hold > 1) tick(hold - 1);
      tx_start = 1'b0;
      data_in  = 8'($urandom);
      tick(FR + 12);
      for (int k = 0; k < 10; k++) begin
         ix = c1 + 14'(k * BD + BD / 2);
         chk($sformatf("tx_bit%0d_%h", k, b), 32'(txlog[ix]), 32'(bits[k]));
      end
      busy_n = 0;
      for (int k = 0; k < FR + 10; k++) begin
         ix = c1 + 14'(k);
         if (busylog[ix]) busy_n++;
      end
      chk($sformatf("tx_busy_len_%h", b), 32'(busy_n), 32'(FR));
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop_ok, input int gap);
      logic [9:0] fr;
      fr = {stop_ok, b, 1'b0};
      if (stop_ok) exp_q.push_back(b);
      for (int k = 0; k < 10; k++) begin
         rx_drv = fr[k];
         tick(BD);
      end
      rx_drv = 1'b1;
      tick(gap);
      chk("rx_missing", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // reset held 5 clocks
      tick(5);
      chk("reset_tx", 32'(tx), 32'd1);
      chk("reset_busy", 32'(tx_busy), 32'd0);
      chk("reset_done", 32'(rx_done), 32'd0);
      chk("reset_dout", 32'(data_out), 32'd0);
      reset_n = 1'b0;
      tick(2);

      tx_lit(8'h05, 10'b1000001010, 2);
      tick(10);
      tx_lit(8'h3C, 10'b1001111000, 1);

      rx_frame(8'h2B, 1'b1, 2 * BD + 4);
      chk("rx_2B", 32'(data_out), 32'h2B);
      rx_frame(8'h55, 1'b1, 2 * BD + 4);
      chk("rx_55", 32'(data_out), 32'h55);

      rx_drv = 1'b0;
      tick(1);
      rx_drv = 1'b1;
      tick(3 * BD);
      rx_frame(8'hA7, 1'b0, 2 * BD + 4);
      chk("ferr_keep", 32'(data_out), 32'h55);
      rx_frame(8'hC3, 1'b1, 2 * BD + 4);
      chk("rx_after_err", 32'(data_out), 32'hC3);

      // reset in the middle of a TX frame
      data_in  = 8'hFF;
      tx_start = 1'b1;
      tick(1);
      tx_start = 1'b0;
      tick(15);
      reset_n = 1'b1;
      tick(1);
      chk("midrst_tx", 32'(tx), 32'd1);
      chk("midrst_busy", 32'(tx_busy), 32'd0);
      chk("midrst_dout", 32'(data_out), 32'd0);
      reset_n = 1'b0;
      tick(3);
      tx_lit(8'h81, 10'b1100000010, 1);

      // random TX: variable hold (long holds give back-to-back frames), data_in churn
      for (int i = 0; i < 30; i++) begin
         int hold;
         hold     = $urandom_range(1, 50);
         data_in  = 8'($urandom);
         tx_start = 1'b1;
         for (int h = 0; h < hold; h++) begin
            tick(1);
            data_in = 8'($urandom);
         end
         tx_start = 1'b0;
         tick($urandom_range(0, 50));
      end
      tick(FR + 5);

      // random RX: mostly good frames, some framing errors and glitches
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            rx_drv = 1'b0;
            tick(1);
            rx_drv = 1'b1;
            tick(2 * BD);
         end
         rx_frame(8'($urandom), ($urandom_range(0, 5) != 0), $urandom_range(2 * BD + 2, 20));
      end

      // loopback: tx feeds rx
      lb = 1'b1;
      tick(2);
      for (int i = 0; i < 20; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         exp_q.push_back(b);
         data_in  = b;
         tx_start = 1'b1;
         tick(1);
         tx_start = 1'b0;
         tick(FR + $urandom_range(4, 10));
         chk("lb_missing", 32'(exp_q.size()), 32'd0);
      end
      lb = 1'b0;
      tick(5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
